// File: rtl/memory_port_arbiter.sv
// Arbitrates the single data-memory port between the load unit and the store buffer,
// with one outstanding bus transaction, starvation guard, timeout and flush handling.
module memory_port_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  input  logic [1:0]  ld_width_i,
  output logic        ld_gnt_o,
  output logic        ld_valid_o,
  output logic [31:0] ld_data_o,
  output logic        ld_err_o,
  input  logic        st_req_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  input  logic [1:0]  st_width_i,
  input  logic        st_buf_full_i,
  output logic        st_gnt_o,
  output logic        st_done_o,
  output logic        st_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [1:0]  bus_width_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i,
  output logic        idle_o
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_WAIT  = 2'd1,
    ST_STORE_WAIT = 2'd2
  } state_e;

  state_e        state_r;
  logic [SW-1:0] starve_cnt_r;
  logic [TW-1:0] to_cnt_r;
  logic          discard_r;
  logic          ld_gnt_s;
  logic          st_gnt_s;
  logic          drop_ld_s;

  // Grant selection, only meaningful while idle.
  always_comb begin
    ld_gnt_s = 1'b0;
    st_gnt_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (st_req_i && (st_buf_full_i || (starve_cnt_r == STARVE_MAX))) begin
        st_gnt_s = 1'b1;
      end else if (ld_req_i && !flush_i) begin
        ld_gnt_s = 1'b1;
      end else if (st_req_i) begin
        st_gnt_s = 1'b1;
      end else begin
        st_gnt_s = 1'b0;
      end
    end else begin
      ld_gnt_s = 1'b0;
      st_gnt_s = 1'b0;
    end
  end

  // A flush arriving on the completion cycle also kills the load response.
  assign drop_ld_s = discard_r | flush_i;

  assign ld_gnt_o = ld_gnt_s;
  assign st_gnt_o = st_gnt_s;
  assign idle_o   = (state_r == ST_IDLE) & ~ld_req_i & ~st_req_i;

  // Transaction sequencer with registered bus fields and response pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= ST_IDLE;
      starve_cnt_r <= '0;
      to_cnt_r     <= '0;
      discard_r    <= 1'b0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= 32'd0;
      bus_wdata_o  <= 32'd0;
      bus_width_o  <= 2'd0;
      ld_valid_o   <= 1'b0;
      ld_data_o    <= 32'd0;
      ld_err_o     <= 1'b0;
      st_done_o    <= 1'b0;
      st_err_o     <= 1'b0;
    end else begin
      ld_valid_o <= 1'b0;
      st_done_o  <= 1'b0;

      if (!st_req_i || st_gnt_s) begin
        starve_cnt_r <= '0;
      end else if (ld_gnt_s && (starve_cnt_r != STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end

      case (state_r)
        ST_IDLE: begin
          to_cnt_r  <= '0;
          discard_r <= 1'b0;
          if (ld_gnt_s) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= ld_addr_i;
            bus_width_o <= ld_width_i;
            state_r     <= ST_LOAD_WAIT;
          end else if (st_gnt_s) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b1;
            bus_addr_o  <= st_addr_i;
            bus_wdata_o <= st_data_i;
            bus_width_o <= st_width_i;
            state_r     <= ST_STORE_WAIT;
          end else begin
            bus_req_o <= 1'b0;
          end
        end
        ST_LOAD_WAIT: begin
          if (bus_ack_i || (to_cnt_r == TO_LAST)) begin
            bus_req_o <= 1'b0;
            discard_r <= 1'b0;
            state_r   <= ST_IDLE;
            if (!drop_ld_s) begin
              ld_valid_o <= 1'b1;
              if (bus_ack_i) begin
                ld_data_o <= bus_rdata_i;
                ld_err_o  <= bus_err_i;
              end else begin
                ld_err_o  <= 1'b1;
              end
            end
          end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
            if (flush_i) begin
              discard_r <= 1'b1;
            end
          end
        end
        ST_STORE_WAIT: begin
          if (bus_ack_i || (to_cnt_r == TO_LAST)) begin
            bus_req_o <= 1'b0;
            state_r   <= ST_IDLE;
            st_done_o <= 1'b1;
            st_err_o  <= bus_ack_i ? bus_err_i : 1'b1;
          end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
          end
        end
        default: begin
          bus_req_o <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: directed stimulus pushes expected bus
// transactions and responses; a negedge monitor pops and compares.
module tb_memory_port_arbiter;

  logic        clk, rst_n, flush;
  logic        ld_req, ld_gnt, ld_valid, ld_err;
  logic [31:0] ld_addr, ld_data;
  logic [1:0]  ld_width;
  logic        st_req, st_buf_full, st_gnt, st_done, st_err;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_width;
  logic        bus_req, bus_we, bus_ack, bus_err, idle;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  bus_width;

  memory_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_width_i(ld_width), .ld_gnt_o(ld_gnt),
    .ld_valid_o(ld_valid), .ld_data_o(ld_data), .ld_err_o(ld_err),
    .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data), .st_width_i(st_width),
    .st_buf_full_i(st_buf_full), .st_gnt_o(st_gnt), .st_done_o(st_done), .st_err_o(st_err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_width_o(bus_width), .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(bus_rdata),
    .idle_o(idle)
  );

  localparam logic [31:0] RKEY = 32'hDEAD_BFEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
  } bus_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t ld_q[$];
  rsp_t st_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int ack_lat = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus model: acks on the ack_lat-th cycle of a request; ack_lat 0 never acks.
  initial begin
    int hi;
    hi = 0;
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_req) begin
        hi++;
        bus_ack   = (ack_lat != 0) && (hi == ack_lat);
        bus_rdata = bus_addr ^ RKEY;
      end else begin
        hi = 0;
        bus_ack = 1'b0;
      end
    end
  end

  // Monitor: bus request rising edge and response pulses.
  initial begin
    logic prev_req;
    bus_t eb;
    rsp_t er;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req && !prev_req) begin
        rise_cyc = cyc;
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_req", 32'd1, 32'd0);
        end else begin
          eb = bus_q.pop_front();
          chk("bus_we", {31'd0, bus_we}, {31'd0, eb.we});
          chk("bus_addr", bus_addr, eb.addr);
          chk("bus_width", {30'd0, bus_width}, {30'd0, eb.width});
          if (eb.we) chk("bus_wdata", bus_wdata, eb.wdata);
        end
      end
      prev_req = bus_req;
      if (ld_valid) begin
        if (ld_q.size() == 0) begin
          chk("unexpected_ld_valid", 32'd1, 32'd0);
        end else begin
          er = ld_q.pop_front();
          chk("ld_err", {31'd0, ld_err}, {31'd0, er.err});
          if (!er.err) chk("ld_data", ld_data, er.data);
          chk("ld_latency", 32'(cyc - rise_cyc), 32'(er.lat));
        end
      end
      if (st_done) begin
        if (st_q.size() == 0) begin
          chk("unexpected_st_done", 32'd1, 32'd0);
        end else begin
          er = st_q.pop_front();
          chk("st_err", {31'd0, st_err}, {31'd0, er.err});
          chk("st_latency", 32'(cyc - rise_cyc), 32'(er.lat));
        end
      end
    end
  end

  task automatic push_ld(input logic [31:0] a, input logic [1:0] w, input bit respond, input int lat);
    bus_q.push_back('{we: 1'b0, addr: a, wdata: 32'd0, width: w});
    if (respond) ld_q.push_back('{data: a ^ RKEY, err: 1'b0, lat: lat});
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                         input logic err, input int lat);
    bus_q.push_back('{we: 1'b1, addr: a, wdata: d, width: w});
    st_q.push_back('{data: 32'd0, err: err, lat: lat});
  endtask

  // Waits (bounded) for a grant at negedge; reports which one and the cycle.
  task automatic wait_grant(output bit gl, output bit gs, output int gc);
    gl = 1'b0; gs = 1'b0; gc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ld_gnt || st_gnt) begin
        gl = ld_gnt; gs = st_gnt; gc = cyc;
        return;
      end
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ld_q.size() == 0 && st_q.size() == 0 && bus_q.size() == 0 && !bus_req) return;
    end
    chk(name, 32'd0, 32'd1);
  endtask

  task automatic at_drive;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit gl, gs;
    int gc, g1, li;
    rst_n = 1'b0; flush = 1'b0;
    ld_req = 1'b0; ld_addr = 32'd0; ld_width = 2'd0;
    st_req = 1'b0; st_addr = 32'd0; st_data = 32'd0; st_width = 2'd0; st_buf_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
    chk("rst_st_done", {31'd0, st_done}, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    rst_n = 1'b1;

    // 1: simple load, ack on third request cycle
    ack_lat = 3;
    push_ld(32'h0000_0100, 2'b10, 1'b1, 3);
    at_drive(); ld_addr = 32'h0000_0100; ld_width = 2'b10; ld_req = 1'b1;
    wait_grant(gl, gs, gc);
    chk("t1_load_gnt", {31'd0, gl}, 32'd1);
    at_drive(); ld_req = 1'b0;
    drain("t1_drain");
    chk("t1_ld_data_hold", ld_data, 32'hDEAD_BEEF);

    // 2: both held, four loads then forced store then loads
    ack_lat = 1;
    for (int i = 0; i < 4; i++) push_ld(32'h200 + 32'(4 * i), 2'b10, 1'b1, 1);
    push_st(32'h300, 32'h1111_2222, 2'b10, 1'b0, 1);
    push_ld(32'h210, 2'b10, 1'b1, 1);
    push_ld(32'h214, 2'b10, 1'b1, 1);
    li = 0;
    at_drive(); ld_addr = 32'h200; ld_width = 2'b10; ld_req = 1'b1;
    st_addr = 32'h300; st_data = 32'h1111_2222; st_width = 2'b10; st_req = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      wait_grant(gl, gs, gc);
      chk("t2_grant_kind", {30'd0, gl, gs}, (n == 5) ? 32'd1 : 32'd2);
      if (gl) li++;
      at_drive(); ld_addr = 32'h200 + 32'(4 * li);
      if (n == 7) begin ld_req = 1'b0; st_req = 1'b0; end
    end
    drain("t2_drain");

    // 3: simultaneous requests with full store buffer
    ack_lat = 2;
    push_st(32'h400, 32'hCAFE_F00D, 2'b01, 1'b0, 2);
    push_ld(32'h500, 2'b00, 1'b1, 2);
    at_drive(); ld_addr = 32'h500; ld_width = 2'b00; ld_req = 1'b1;
    st_addr = 32'h400; st_data = 32'hCAFE_F00D; st_width = 2'b01; st_req = 1'b1; st_buf_full = 1'b1;
    wait_grant(gl, gs, gc);
    chk("t3_store_first", {30'd0, gl, gs}, 32'd1);
    at_drive(); st_req = 1'b0; st_buf_full = 1'b0;
    wait_grant(gl, gs, gc);
    chk("t3_then_load", {30'd0, gl, gs}, 32'd2);
    at_drive(); ld_req = 1'b0;
    drain("t3_drain");

    // 4: flush during LOAD_WAIT suppresses response; regrant right after ack
    ack_lat = 4;
    push_ld(32'h600, 2'b10, 1'b0, 4);
    push_ld(32'h700, 2'b10, 1'b1, 4);
    at_drive(); ld_addr = 32'h600; ld_width = 2'b10; ld_req = 1'b1;
    wait_grant(gl, gs, g1);
    at_drive(); ld_req = 1'b0; flush = 1'b1;
    at_drive(); flush = 1'b0; ld_addr = 32'h700; ld_req = 1'b1;
    wait_grant(gl, gs, gc);
    chk("t4_regrant_gap", 32'(gc - g1), 32'd5);
    at_drive(); ld_req = 1'b0;
    drain("t4_drain");

    // 5: store timeout after 64 wait cycles
    ack_lat = 0;
    push_st(32'h800, 32'h0BAD_F00D, 2'b10, 1'b1, 64);
    at_drive(); st_addr = 32'h800; st_data = 32'h0BAD_F00D; st_width = 2'b10; st_req = 1'b1;
    wait_grant(gl, gs, gc);
    at_drive(); st_req = 1'b0;
    drain("t5_drain");
    chk("t5_bus_req_low", {31'd0, bus_req}, 32'd0);
    chk("t5_idle", {31'd0, idle}, 32'd1);

    // 6: reset during LOAD_WAIT abandons the transaction
    push_ld(32'h900, 2'b10, 1'b0, 0);
    at_drive(); ld_addr = 32'h900; ld_req = 1'b1;
    wait_grant(gl, gs, gc);
    at_drive(); ld_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_bus_req_drop", {31'd0, bus_req}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_after", {31'd0, idle}, 32'd1);
    repeat (8) @(negedge clk);

    // 7: flush in IDLE blocks a load grant for that cycle only
    ack_lat = 1;
    push_ld(32'hA00, 2'b01, 1'b1, 1);
    at_drive(); ld_addr = 32'hA00; ld_width = 2'b01; ld_req = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("t7_flush_blocks", {31'd0, ld_gnt}, 32'd0);
    at_drive(); flush = 1'b0;
    @(negedge clk);
    chk("t7_grant_after", {31'd0, ld_gnt}, 32'd1);
    at_drive(); ld_req = 1'b0;
    drain("t7_drain");

    repeat (3) @(negedge clk);
    chk("end_bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("end_ld_q_empty", 32'(ld_q.size()), 32'd0);
    chk("end_st_q_empty", 32'(st_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
